// File: rtl/izhikevich_scheduler.sv
// Time-multiplexes one izhikevich_core over NEURONS virtual neurons.
// Optional per-neuron spike counters: define IZH_SCHED_SPIKE_COUNT_EN.
module izhikevich_scheduler #(
    parameter int N       = 20,
    parameter int Q       = 8,
    parameter int NEURONS = 8,
    parameter int IDX_W   = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    input  logic               init_wr_en,
    input  logic [IDX_W-1:0]   init_idx,
    input  logic [N-1:0]       init_v,
    input  logic [N-1:0]       init_w,
    input  logic               cur_wr_en,
    input  logic [IDX_W-1:0]   cur_idx,
    input  logic [N-1:0]       cur_data,
    input  logic [IDX_W-1:0]   rd_idx,
    output logic [N-1:0]       rd_v,
    output logic [N-1:0]       rd_w,
    output logic               spike_valid,
    output logic [IDX_W-1:0]   spike_idx,
    output logic               spike,
    output logic [NEURONS-1:0] spike_vec,
    output logic               core_rst,
    output logic               core_apply,
    output logic [N-1:0]       core_i,
    output logic [N-1:0]       core_v_init,
    output logic [N-1:0]       core_w_init,
    input  logic [N-1:0]       core_voltage,
    input  logic [N-1:0]       core_w,
    input  logic               core_spiking,
    output logic [7:0]         rd_count
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_STEP  = 3'd2;
    localparam logic [2:0] S_STORE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    if (Q >= N || NEURONS < 2 || NEURONS > 256 || (1 << IDX_W) < NEURONS) begin : g_bad_cfg
        $error("izhikevich_scheduler: inconsistent parameters");
    end

    logic [2:0]         state_q, state_d;
    logic [IDX_W-1:0]   k_q, k_d;
    logic [N-1:0]       v_q [NEURONS];
    logic [N-1:0]       v_d [NEURONS];
    logic [N-1:0]       w_q [NEURONS];
    logic [N-1:0]       w_d [NEURONS];
    logic [N-1:0]       cur_q [NEURONS];
    logic [N-1:0]       cur_d [NEURONS];
    logic [NEURONS-1:0] stage_q, stage_d;
    logic [NEURONS-1:0] vec_q, vec_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               sv_q, sv_d;
    logic               crst_q, crst_d;
    logic               capp_q, capp_d;
    logic [N-1:0]       ci_q, ci_d;
    logic [N-1:0]       cvi_q, cvi_d;
    logic [N-1:0]       cwi_q, cwi_d;
    logic               last;

    assign last = (k_q == IDX_W'(NEURONS - 1));

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    k_d     = '0;
                end
            end
            S_LOAD:  state_d = S_STEP;
            S_STEP:  state_d = S_STORE;
            S_STORE: begin
                if (last) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_LOAD;
                    k_d     = k_q + IDX_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Host init writes lose to the sweep, which owns the bank while busy.
    always_comb begin
        v_d     = v_q;
        w_d     = w_q;
        cur_d   = cur_q;
        stage_d = stage_q;
        vec_d   = vec_q;
        if (init_wr_en && !busy_q) begin
            v_d[init_idx] = init_v;
            w_d[init_idx] = init_w;
        end
        if (cur_wr_en) begin
            cur_d[cur_idx] = cur_data;
        end
        if (state_q == S_STORE) begin
            v_d[k_q]     = core_voltage;
            w_d[k_q]     = core_w;
            stage_d[k_q] = core_spiking;
        end
        if (state_q == S_DONE) begin
            vec_d = stage_q;
        end
    end

    always_comb begin
        busy_d = (state_d == S_LOAD) || (state_d == S_STEP) || (state_d == S_STORE);
        done_d = (state_d == S_DONE);
        sv_d   = (state_d == S_STORE);
        crst_d = (state_d == S_LOAD);
        capp_d = (state_d == S_STEP);
        ci_d   = '0;
        cvi_d  = '0;
        cwi_d  = '0;
        if (state_d == S_LOAD) begin
            ci_d  = cur_q[k_d];
            cvi_d = v_q[k_d];
            cwi_d = w_q[k_d];
        end else if (state_d == S_STEP) begin
            ci_d = ci_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            v_q     <= '{default: '0};
            w_q     <= '{default: '0};
            cur_q   <= '{default: '0};
            stage_q <= '0;
            vec_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sv_q    <= 1'b0;
            crst_q  <= 1'b0;
            capp_q  <= 1'b0;
            ci_q    <= '0;
            cvi_q   <= '0;
            cwi_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            v_q     <= v_d;
            w_q     <= w_d;
            cur_q   <= cur_d;
            stage_q <= stage_d;
            vec_q   <= vec_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sv_q    <= sv_d;
            crst_q  <= crst_d;
            capp_q  <= capp_d;
            ci_q    <= ci_d;
            cvi_q   <= cvi_d;
            cwi_q   <= cwi_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign spike_valid = sv_q;
    assign spike_idx   = k_q;
    assign spike       = sv_q & core_spiking;
    assign spike_vec   = vec_q;
    assign core_rst    = crst_q;
    assign core_apply  = capp_q;
    assign core_i      = ci_q;
    assign core_v_init = cvi_q;
    assign core_w_init = cwi_q;
    assign rd_v        = v_q[rd_idx];
    assign rd_w        = w_q[rd_idx];

`ifdef IZH_SCHED_SPIKE_COUNT_EN
    logic [7:0] cnt_q [NEURONS];
    logic [7:0] cnt_d [NEURONS];

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_STORE && core_spiking && cnt_q[k_q] != 8'hFF) begin
            cnt_d[k_q] = cnt_q[k_q] + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '{default: '0};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign rd_count = cnt_q[rd_idx];
`else
    assign rd_count = 8'd0;
`endif

endmodule
